ifetch_prefetch: RTL

Instruction-fetch front end that sits directly upstream of the single-cycle MIPS core's IR/IR_addr port. It prefetches sequential instruction words from a variable-latency instruction memory into a small FIFO. The head word is presented to the core as IR together with a valid/stall indication. A non-sequential IR_addr (jump, branch, jr, reset) flushes the FIFO and redirects fetch.

---
 rtl/ifetch_prefetch.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch front end: streams sequential words from a variable-latency
// instruction memory into a small FIFO and serves the core's IR/IR_addr port.
module ifetch_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IR_addr,
    input  logic        IR_take,
    output logic [31:0] IR,
    output logic        IR_valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] PC0       = {RESET_PC[31:2], 2'b00};
    localparam logic [31:0] WORD      = 32'd4;
    localparam logic [AW:0] CNT_ONE   = 1;
    localparam logic [AW:0] CNT_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_LAST  = (AW + 1)'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t        state;
    logic [31:0]   fifo_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_after;
    logic [31:0]   exp_addr;
    logic [31:0]   fetch_addr;
    logic [31:0]   target_addr;
    logic          redirect;
    logic          pop;
    logic          push;
    logic          unused_addr_bits;

    assign unused_addr_bits = &{1'b0, IR_addr[1:0]};

    assign target_addr = {IR_addr[31:2], 2'b00};
    assign redirect    = IR_addr[31:2] != exp_addr[31:2];
    assign IR_valid    = (count != '0) && !redirect;
    assign IR          = IR_valid ? fifo_mem[rd_ptr] : 32'h0;
    assign pop         = IR_valid && IR_take;
    assign push        = (state == REQ) && mem_ack && !redirect;

    always_comb begin
        count_after = count;
        if (push && !pop)
            count_after = count + CNT_ONE;
        else if (pop && !push)
            count_after = count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= mem_rdata;
    end

    // A redirect flushes everything; an in-flight request must still drain its ack in DISCARD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            exp_addr   <= PC0;
            fetch_addr <= PC0;
            mem_req    <= 1'b0;
            mem_addr   <= PC0;
        end else if (redirect) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            exp_addr   <= target_addr;
            fetch_addr <= target_addr;
            case (state)
                REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        state   <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end else begin
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                exp_addr <= exp_addr + WORD;
            end
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            count <= count_after;

            // Issue only while a FIFO slot is guaranteed for the returning word.
            case (state)
                IDLE: begin
                    if (count != CNT_FULL) begin
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_addr;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        fetch_addr <= fetch_addr + WORD;
                        if (count_after < CNT_LAST) begin
                            mem_addr <= fetch_addr + WORD;
                            state    <= REQ;
                        end else begin
                            mem_req  <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
